mux_n1_stream: RTL and testbench

// - Parametrised N:1 WIDTH-bit stream multiplexer; successor to the 2:1 bit mux.
// - Selects one of N valid/ready input channels and registers it into a single output stage.
// - Two modes:
//   - fixed: the external sel port picks the channel.
//   - round-robin: an internal fair arbiter picks the channel.
// - Sits between producer channels and one shared consumer (bus, FIFO, UART TX).

---
 rtl/mux_pkg.sv | 17 +
 rtl/mux_rr_pick.sv | 41 ++++
 rtl/mux_n1_stream.sv | 95 +++++++++
 tb/tb_mux_n1_stream.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mux_pkg.sv
// Shared constants and helpers for the N:1 stream multiplexer family.
package mux_pkg;

  localparam int MODE_FIXED = 0;
  localparam int MODE_RR    = 1;

  // Number of bits needed to index 'value' items; never less than 1.
  function automatic int clog2(input int value);
    int r;
    r = 1;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/mux_rr_pick.sv
// Rotate-priority picker: grants the first requester found searching
// ptr, ptr+1, ... N-1, 0, ... ptr-1. Purely combinational.
module mux_rr_pick
  import mux_pkg::*;
#(
  parameter int  N    = 4,
  localparam int SELW = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] ptr,
  output logic [SELW-1:0] gnt_idx,
  output logic            gnt_vld
);

  logic [2*N-1:0]  req_dbl;
  logic [SELW-1:0] offset;
  logic [SELW:0]   idx_sum;

  // Rotating the doubled request vector puts req[ptr] at bit 0
  assign req_dbl = {req, req} >> ptr;

  // Lowest set bit of the rotated vector is the winner; scanning downward lets it overwrite
  always_comb begin
    gnt_vld = 1'b0;
    offset  = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req_dbl[k]) begin
        gnt_vld = 1'b1;
        offset  = SELW'(k);
      end
    end
  end

  // Map the rotated offset back to an absolute channel index, modulo N
  always_comb begin
    idx_sum = {1'b0, ptr} + {1'b0, offset};
    if (idx_sum >= (SELW + 1)'(N)) idx_sum = idx_sum - (SELW + 1)'(N);
    gnt_idx = idx_sum[SELW-1:0];
  end

endmodule

// File: rtl/mux_n1_stream.sv
// N:1 valid/ready stream multiplexer with one registered output stage.
// Channel choice comes from the sel port (fixed mode) or from an internal
// round-robin pointer (rr mode). The output register accepts a new word
// whenever it is empty or being drained in the same cycle.
module mux_n1_stream
  import mux_pkg::*;
#(
  parameter int  N     = 4,
  parameter int  WIDTH = 8,
  parameter int  MODE  = MODE_FIXED,
  localparam int SELW  = clog2(N)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [SELW-1:0]    sel,
  input  logic [N*WIDTH-1:0] in_data,
  input  logic [N-1:0]       in_valid,
  output logic [N-1:0]       in_ready,
  output logic [WIDTH-1:0]   out_data,
  output logic [SELW-1:0]    out_ch,
  output logic               out_valid,
  input  logic               out_ready
);

  logic [SELW-1:0]  g;
  logic             gnt_vld;
  logic             ld;
  logic [WIDTH-1:0] g_data;

  generate
    if (MODE == MODE_RR) begin : g_rr
      logic [SELW-1:0] ptr;
      logic            unused_sel;

      assign unused_sel = ^sel;

      mux_rr_pick #(.N(N)) u_pick (
        .req     (in_valid),
        .ptr     (ptr),
        .gnt_idx (g),
        .gnt_vld (gnt_vld)
      );

      // Move the search start just past the channel served, so a waiting channel gets its turn
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          ptr <= '0;
        end else if (ld) begin
          ptr <= (g == SELW'(N - 1)) ? '0 : g + 1'b1;
        end
      end
    end else begin : g_fixed
      // sel drives the grant directly; a sel beyond N-1 matches no channel and grants nothing
      always_comb begin
        g       = sel;
        gnt_vld = 1'b0;
        for (int i = 0; i < N; i++) begin
          if (sel == SELW'(i)) gnt_vld = in_valid[i];
        end
      end
    end
  endgenerate

  // Load when the output slot is free (or freeing now) and the granted channel has data;
  // rst_n gates it so nothing is offered upstream while in reset
  assign ld = rst_n & (~out_valid | out_ready) & gnt_vld;

  // Data mux and one-hot ready decode for the granted channel
  always_comb begin
    g_data   = '0;
    in_ready = '0;
    for (int i = 0; i < N; i++) begin
      if (g == SELW'(i)) begin
        g_data      = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = ld;
      end
    end
  end

  // Output stage: capture on load, otherwise empty once the consumer takes the word
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
    end else if (ld) begin
      out_valid <= 1'b1;
      out_data  <= g_data;
      out_ch    <= g;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_n1_stream.sv
// Bench for mux_n1_stream: fixed-select (N=4 and N=3) and round-robin (N=4)
// instances, checked through expected-output queues drained by monitors.
module tb_mux_n1_stream;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // DUT A: N=4 fixed select
  logic [1:0]  a_sel;
  logic [31:0] a_in_data;
  logic [3:0]  a_in_valid, a_in_ready;
  logic [7:0]  a_out_data;
  logic [1:0]  a_out_ch;
  logic        a_out_valid, a_out_ready;

  // DUT B: N=3 fixed select (sel=3 is out of range)
  logic [1:0]  b_sel;
  logic [23:0] b_in_data;
  logic [2:0]  b_in_valid, b_in_ready;
  logic [7:0]  b_out_data;
  logic [1:0]  b_out_ch;
  logic        b_out_valid, b_out_ready;

  // DUT C: N=4 round-robin
  logic [1:0]  c_sel;
  logic [31:0] c_in_data;
  logic [3:0]  c_in_valid, c_in_ready;
  logic [7:0]  c_out_data;
  logic [1:0]  c_out_ch;
  logic        c_out_valid, c_out_ready;

  mux_n1_stream #(.N(4), .WIDTH(8), .MODE(0)) u_a (
    .clk(clk), .rst_n(rst_n), .sel(a_sel), .in_data(a_in_data), .in_valid(a_in_valid),
    .in_ready(a_in_ready), .out_data(a_out_data), .out_ch(a_out_ch),
    .out_valid(a_out_valid), .out_ready(a_out_ready));

  mux_n1_stream #(.N(3), .WIDTH(8), .MODE(0)) u_b (
    .clk(clk), .rst_n(rst_n), .sel(b_sel), .in_data(b_in_data), .in_valid(b_in_valid),
    .in_ready(b_in_ready), .out_data(b_out_data), .out_ch(b_out_ch),
    .out_valid(b_out_valid), .out_ready(b_out_ready));

  mux_n1_stream #(.N(4), .WIDTH(8), .MODE(1)) u_c (
    .clk(clk), .rst_n(rst_n), .sel(c_sel), .in_data(c_in_data), .in_valid(c_in_valid),
    .in_ready(c_in_ready), .out_data(c_out_data), .out_ch(c_out_ch),
    .out_valid(c_out_valid), .out_ready(c_out_ready));

  // Expected {ch, data} words in output order
  logic [9:0] exp_a[$];
  logic [9:0] exp_b[$];
  logic [9:0] exp_c[$];
  // Random phase: per-channel expected data in acceptance order
  logic [7:0] chq[4][$];
  logic [5:0] seq[4];
  int         starve[4];
  int         pushed = 0;
  int         popped = 0;
  logic       c_rand = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic chk_empty(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=output_word required=no_output", name);
  endtask

  // Monitor A
  always @(negedge clk) begin : mon_a
    logic [9:0] e;
    if (rst_n && a_out_valid && a_out_ready) begin
      if (exp_a.size() == 0) chk_empty("a_unexpected");
      else begin
        e = exp_a.pop_front();
        chk("a_mon_data", a_out_data, e[7:0]);
        chk("a_mon_ch", a_out_ch, e[9:8]);
      end
    end
  end

  // Monitor B
  always @(negedge clk) begin : mon_b
    logic [9:0] e;
    if (rst_n && b_out_valid && b_out_ready) begin
      if (exp_b.size() == 0) chk_empty("b_unexpected");
      else begin
        e = exp_b.pop_front();
        chk("b_mon_data", b_out_data, e[7:0]);
        chk("b_mon_ch", b_out_ch, e[9:8]);
      end
    end
  end

  // Monitor C output side
  always @(negedge clk) begin : mon_c
    logic [9:0] e;
    logic [7:0] d;
    if (rst_n && c_out_valid && c_out_ready) begin
      if (!c_rand) begin
        if (exp_c.size() == 0) chk_empty("c_unexpected");
        else begin
          e = exp_c.pop_front();
          chk("c_rr_data", c_out_data, e[7:0]);
          chk("c_rr_ch", c_out_ch, e[9:8]);
        end
      end else begin
        if (chq[c_out_ch].size() == 0) chk_empty("c_stream_unexpected");
        else begin
          d = chq[c_out_ch].pop_front();
          chk("c_stream_data", c_out_data, d);
          popped++;
        end
      end
    end
  end

  // Monitor C input side (random phase): record accepted words, check fairness
  always @(negedge clk) begin : mon_c_in
    logic xfer;
    int   xch;
    if (rst_n && c_rand) begin
      chk("c_ready_onehot", ($countones(c_in_ready) <= 1), 1);
      chk("c_ready_subset", c_in_ready & ~c_in_valid, 0);
      xfer = 1'b0;
      xch  = 0;
      for (int i = 0; i < 4; i++) begin
        if (c_in_valid[i] && c_in_ready[i]) begin
          chq[i].push_back(c_in_data[i*8 +: 8]);
          seq[i] = seq[i] + 6'd1;
          pushed++;
          xfer = 1'b1;
          xch  = i;
        end
      end
      for (int i = 0; i < 4; i++) begin
        if (!c_in_valid[i] || (xfer && xch == i)) starve[i] = 0;
        else if (xfer) begin
          starve[i]++;
          chk("c_starve", (starve[i] <= 3), 1);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    a_sel = 2'd2; a_in_data = '0; a_in_valid = 4'b0100; a_out_ready = 1'b1;
    b_sel = 2'd0; b_in_data = '0; b_in_valid = '0;      b_out_ready = 1'b1;
    c_sel = 2'd0; c_in_data = '0; c_in_valid = 4'b1111; c_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin seq[i] = '0; starve[i] = 0; end

    // Reset state, with valid inputs present to show ready is gated
    #12;
    chk("rst_out_valid", a_out_valid, 0);
    chk("rst_out_data", a_out_data, 0);
    chk("rst_out_ch", a_out_ch, 0);
    chk("rst_a_in_ready", a_in_ready, 0);
    chk("rst_c_in_ready", c_in_ready, 0);
    a_in_valid = '0;
    c_in_valid = '0;
    #6 rst_n = 1'b1;

    // Fixed select, single word on channel 2
    @(posedge clk); #1;
    a_sel = 2'd2; a_in_valid = 4'b0100; a_in_data = 32'h00A5_0000;
    exp_a.push_back({2'd2, 8'hA5});
    #1 chk("a_in_ready_sel2", a_in_ready, 4'b0100);
    @(posedge clk); #1;
    a_in_valid = '0;
    chk("a_out_data_a5", a_out_data, 8'hA5);
    chk("a_out_ch_2", a_out_ch, 2);
    chk("a_out_valid_1", a_out_valid, 1);
    @(posedge clk); #1;
    chk("a_out_valid_drain", a_out_valid, 0);

    // sel changes between back-to-back words
    a_in_valid = 4'b1111; a_in_data = 32'h3322_1110; a_sel = 2'd0;
    exp_a.push_back({2'd0, 8'h10});
    #1 chk("a_in_ready_sel0", a_in_ready, 4'b0001);
    @(posedge clk); #1;
    a_sel = 2'd3;
    exp_a.push_back({2'd3, 8'h33});
    #1 chk("a_in_ready_sel3", a_in_ready, 4'b1000);
    chk("a_b2b_first", a_out_data, 8'h10);
    @(posedge clk); #1;
    a_in_valid = '0;
    chk("a_b2b_second", a_out_data, 8'h33);
    chk("a_b2b_ch", a_out_ch, 3);
    chk("a_b2b_valid", a_out_valid, 1);

    // Backpressure: hold 8'h11, then load the next word the cycle out_ready returns
    @(posedge clk); #1;
    a_sel = 2'd1; a_in_valid = 4'b0010; a_in_data = 32'h0000_1100;
    exp_a.push_back({2'd1, 8'h11});
    @(posedge clk); #1;
    a_out_ready = 1'b0; a_in_data = 32'h0000_2200;
    exp_a.push_back({2'd1, 8'h22});
    for (int k = 0; k < 5; k++) begin
      #1;
      chk("a_hold_data", a_out_data, 8'h11);
      chk("a_hold_ch", a_out_ch, 1);
      chk("a_hold_ready", a_in_ready, 0);
      @(posedge clk); #1;
    end
    a_out_ready = 1'b1;
    #1 chk("a_release_ready", a_in_ready, 4'b0010);
    @(posedge clk); #1;
    a_in_valid = '0;
    chk("a_release_data", a_out_data, 8'h22);
    chk("a_release_valid", a_out_valid, 1);

    // Out-of-range select on N=3: nothing accepted for 10 cycles
    b_sel = 2'd3; b_in_valid = 3'b111; b_in_data = 24'h5C_4B3A;
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("b_oor_ready", b_in_ready, 0);
      chk("b_oor_valid", b_out_valid, 0);
      @(posedge clk); #1;
    end
    b_sel = 2'd2;
    exp_b.push_back({2'd2, 8'h5C});
    #1 chk("b_top_ready", b_in_ready, 3'b100);
    @(posedge clk); #1;
    b_in_valid = '0;
    chk("b_top_data", b_out_data, 8'h5C);
    chk("b_top_ch", b_out_ch, 2);

    // Round-robin, all channels valid, then only 0 and 3 with ptr at 2
    c_out_ready = 1'b1; c_in_data = 32'hC3C2_C1C0; c_in_valid = 4'b1111;
    exp_c.push_back({2'd0, 8'hC0}); exp_c.push_back({2'd1, 8'hC1});
    exp_c.push_back({2'd2, 8'hC2}); exp_c.push_back({2'd3, 8'hC3});
    exp_c.push_back({2'd0, 8'hC0}); exp_c.push_back({2'd1, 8'hC1});
    exp_c.push_back({2'd3, 8'hC3}); exp_c.push_back({2'd0, 8'hC0});
    exp_c.push_back({2'd3, 8'hC3}); exp_c.push_back({2'd0, 8'hC0});
    #1 chk("c_first_ready", c_in_ready, 4'b0001);
    repeat (6) @(posedge clk);
    #1 c_in_valid = 4'b1001;
    #1 chk("c_ptr2_ready", c_in_ready, 4'b1000);
    repeat (4) @(posedge clk);
    #1 c_in_valid = '0;
    repeat (3) @(posedge clk);
    #1 chk("c_rr_drained", exp_c.size(), 0);

    // Random streaming on the round-robin instance
    c_rand = 1'b1;
    repeat (10000) begin
      @(posedge clk); #1;
      c_in_valid  = 4'($urandom_range(0, 15));
      c_out_ready = ($urandom_range(0, 9) < 7);
      for (int i = 0; i < 4; i++) c_in_data[i*8 +: 8] = {2'(i), seq[i]};
    end
    @(posedge clk); #1;
    c_in_valid = '0; c_out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    for (int i = 0; i < 4; i++) chk("c_stream_leftover", chq[i].size(), 0);
    chk("c_stream_count", popped, pushed);
    chk("c_stream_nonzero", (pushed > 1000), 1);

    // Reset while a word is held: it must vanish at once
    a_sel = 2'd1; a_in_valid = 4'b0010; a_in_data = 32'h0000_7700; a_out_ready = 1'b1;
    @(posedge clk); #1;
    a_out_ready = 1'b0;
    chk("a_pre_rst_valid", a_out_valid, 1);
    chk("a_pre_rst_data", a_out_data, 8'h77);
    #2 rst_n = 1'b0;
    #1;
    chk("a_midrst_valid", a_out_valid, 0);
    chk("a_midrst_data", a_out_data, 0);
    chk("a_midrst_ch", a_out_ch, 0);
    chk("a_midrst_ready", a_in_ready, 0);
    a_in_valid = '0;
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("a_post_rst_valid", a_out_valid, 0);

    repeat (2) @(posedge clk);
    #1;
    chk("a_drained", exp_a.size(), 0);
    chk("b_drained", exp_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
